// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package register_file_pkg;

  // Sweep FSM: CLEAR zeroes one entry per cycle, RUN is normal operation.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  // Address width for n entries, never less than one bit.
  function automatic int rf_addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback facing bus of the register file.
interface register_file_mp_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int READ_PORTS = 2
);
  localparam int AW = rf_addr_width(NUM_REGS);

  logic [READ_PORTS*AW-1:0]         rdAddr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rdData;
  logic [AW-1:0]                    wrAddr;
  logic [DATA_WIDTH-1:0]            wrData;
  logic                             writeEnable;
  logic                             clear;
  logic                             ready;

  // Decode/writeback side drives addresses and the write port.
  modport master (
    output rdAddr, wrAddr, wrData, writeEnable, clear,
    input  rdData, ready
  );

  // Register file side.
  modport slave (
    input  rdAddr, wrAddr, wrData, writeEnable, clear,
    output rdData, ready
  );
endinterface

// File: rtl/register_file_mp_clear_seq.sv
// Clear-sweep sequencer: owns the CLEAR/RUN FSM, the sweep index and ready.
module register_file_clear_seq
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int AW      = rf_addr_width(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  output rf_state_t       o_state,
  output logic            o_ready,
  output logic            o_clrWe,
  output logic [AW-1:0]   o_clrAddr
);

  // One extra bit so a full power-of-two sweep ends without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_REGS - 1);

  rf_state_t   r_state;
  logic [AW:0] r_clrIdx;
  logic        r_ready;

  // Sweep FSM: walk every entry once, then accept traffic until a clear request.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RF_CLEAR;
      r_clrIdx <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          if (r_clrIdx == LAST_IDX) begin
            r_state  <= RF_RUN;
            r_ready  <= 1'b1;
            r_clrIdx <= '0;
          end else begin
            r_clrIdx <= r_clrIdx + 1'b1;
          end
        end
        RF_RUN: begin
          if (i_clear) begin
            r_state  <= RF_CLEAR;
            r_ready  <= 1'b0;
            r_clrIdx <= '0;
          end
        end
        default: begin
          r_state  <= RF_CLEAR;
          r_ready  <= 1'b0;
          r_clrIdx <= '0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_ready   = r_ready;
  assign o_clrWe   = (r_state == RF_CLEAR);
  assign o_clrAddr = r_clrIdx[AW-1:0];

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with sequential clear sweep and write bypass.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);

  localparam int          AW         = rf_addr_width(NUM_REGS);
  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  rf_state_t     w_state;
  logic          w_clrWe;
  logic [AW-1:0] w_clrAddr;
  logic          w_wrInRange;
  logic          w_wrZero;
  logic          w_wrQual;

  register_file_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (bus.clear),
    .o_state   (w_state),
    .o_ready   (bus.ready),
    .o_clrWe   (w_clrWe),
    .o_clrAddr (w_clrAddr)
  );

  // A write lands only in RUN, in range, not to a hardwired zero entry,
  // and not on the edge that starts a soft clear.
  assign w_wrInRange = ({1'b0, bus.wrAddr} < NUM_REGS_W);
  assign w_wrZero    = (ZERO_REG != 0) && (bus.wrAddr == '0);
  assign w_wrQual    = (w_state == RF_RUN) && !bus.clear && bus.writeEnable
                       && w_wrInRange && !w_wrZero;

  // Array write port: sweep zeroes take the port in CLEAR, qualified writes in RUN.
  // NOTE: the array has no reset; the sweep clears it, so it can map onto RAM or plain flops without reset nets.
  always_ff @(posedge clk) begin
    if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else if (w_wrQual) begin
      r_mem[bus.wrAddr] <= bus.wrData;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]         w_rdAddr;
    logic                  w_rdInRange;
    logic [DATA_WIDTH-1:0] w_rdData;

    assign w_rdAddr    = bus.rdAddr[p*AW +: AW];
    assign w_rdInRange = ({1'b0, w_rdAddr} < NUM_REGS_W);

    // Per-port read mux in priority order: sweep, range, zero reg, bypass, array.
    // NOTE: the default assignment first means every path drives w_rdData, so no latch is inferred.
    always_comb begin
      w_rdData = '0;
      if (w_state != RF_RUN) begin
        w_rdData = '0;
      end else if (!w_rdInRange) begin
        w_rdData = '0;
      end else if ((ZERO_REG != 0) && (w_rdAddr == '0)) begin
        w_rdData = '0;
      end else if ((BYPASS != 0) && w_wrQual && (bus.wrAddr == w_rdAddr)) begin
        w_rdData = bus.wrData;
      end else begin
        w_rdData = r_mem[w_rdAddr];
      end
    end

    assign bus.rdData[p*DATA_WIDTH +: DATA_WIDTH] = w_rdData;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations share one stimulus stream
// and are compared each cycle against a behavioural model of the register file.
module tb_register_file_mp;

  localparam int NDUT = 3;

  logic        clk;
  logic        reset;
  logic [7:0]  rd_addr;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic        clr;

  int n_total = 0;
  int n_bad   = 0;

  // a: 16 entries, zero reg, bypass; b: 16 entries, no zero reg, no bypass; c: 12 entries.
  int unsigned m_n    [NDUT] = '{16, 16, 12};
  bit          m_zero [NDUT] = '{1'b1, 1'b0, 1'b1};
  bit          m_byp  [NDUT] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem  [NDUT][16];
  int          m_busy [NDUT];

  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(16), .READ_PORTS(2)) if_a ();
  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(16), .READ_PORTS(2)) if_b ();
  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(12), .READ_PORTS(2)) if_c ();

  assign if_a.rdAddr = rd_addr;  assign if_b.rdAddr = rd_addr;  assign if_c.rdAddr = rd_addr;
  assign if_a.wrAddr = wr_addr;  assign if_b.wrAddr = wr_addr;  assign if_c.wrAddr = wr_addr;
  assign if_a.wrData = wr_data;  assign if_b.wrData = wr_data;  assign if_c.wrData = wr_data;
  assign if_a.writeEnable = we;  assign if_b.writeEnable = we;  assign if_c.writeEnable = we;
  assign if_a.clear = clr;       assign if_b.clear = clr;       assign if_c.clear = clr;

  register_file_mp #(.DATA_WIDTH(32), .NUM_REGS(16), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  register_file_mp #(.DATA_WIDTH(32), .NUM_REGS(16), .READ_PORTS(2), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  register_file_mp #(.DATA_WIDTH(32), .NUM_REGS(12), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_rd(input int k, input int p);
    case (k)
      0:       return if_a.rdData[p*32 +: 32];
      1:       return if_b.rdData[p*32 +: 32];
      default: return if_c.rdData[p*32 +: 32];
    endcase
  endfunction

  function automatic logic get_ready(input int k);
    case (k)
      0:       return if_a.ready;
      1:       return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Any clear (reset or soft) wipes the contents and makes the file busy for N edges.
  function automatic void m_start_clear(input int k);
    m_busy[k] = int'(m_n[k]);
    for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
  endfunction

  function automatic bit m_wr_qual(input int k);
    return (m_busy[k] == 0) && !clr && we && (wr_addr < m_n[k])
           && !(m_zero[k] && (wr_addr == 4'd0));
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [3:0] a);
    if (m_busy[k] != 0)                        return '0;
    if (a >= m_n[k])                           return '0;
    if (m_zero[k] && a == 4'd0)                return '0;
    if (m_byp[k] && m_wr_qual(k) && wr_addr == a) return wr_data;
    return m_mem[k][a];
  endfunction

  function automatic void m_edge(input int k);
    if (!reset)                m_start_clear(k);
    else if (m_busy[k] != 0)   m_busy[k]--;
    else if (clr)              m_start_clear(k);
    else if (m_wr_qual(k))     m_mem[k][wr_addr] = wr_data;
  endfunction

  // Called at a falling edge with inputs already driven: compare, then take the rising edge.
  task automatic step();
    #2;
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < 2; p++)
        check($sformatf("d%0d_rd%0d_a%0d", k, p, rd_addr[p*4 +: 4]),
              get_rd(k, p), m_read(k, rd_addr[p*4 +: 4]));
      check($sformatf("d%0d_ready", k), 32'(get_ready(k)), 32'(m_busy[k] == 0));
    end
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) m_edge(k);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; clr = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d; clr = 1'b0;
    rd_addr = {a, a};
    step();
  endtask

  // Count edges until ready rises; expected sweep length is the entry count.
  task automatic measure_sweep(input string tag);
    int at [NDUT];
    for (int k = 0; k < NDUT; k++) at[k] = -1;
    for (int n = 0; n <= 24; n++) begin
      for (int k = 0; k < NDUT; k++)
        if (at[k] < 0 && get_ready(k)) at[k] = n;
      if (n < 24) step();
    end
    check({tag, "_len_a"}, 32'(at[0]), 32'd16);
    check({tag, "_len_c"}, 32'(at[2]), 32'd12);
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(15 - a), 4'(a)};
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) m_start_clear(k);
    idle();
    rd_addr = '0;
    reset   = 1'b0;

    // Reset held for three cycles, then the power-on sweep.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    measure_sweep("por");
    read_all();

    // Write/read through both ports; r0 is hardwired zero on a and c only.
    write(4'd5, 32'hDEAD_BEEF);
    idle(); rd_addr = {4'd5, 4'd5};
    #1;
    check("r5_port0_a", get_rd(0, 0), 32'hDEAD_BEEF);
    check("r5_port1_a", get_rd(0, 1), 32'hDEAD_BEEF);
    check("r5_port1_b", get_rd(1, 1), 32'hDEAD_BEEF);
    step();
    write(4'd0, 32'h0000_1234);
    idle(); rd_addr = {4'd0, 4'd0};
    #1;
    check("r0_zero_a", get_rd(0, 0), 32'h0);
    check("r0_plain_b", get_rd(1, 0), 32'h0000_1234);
    step();

    // Same-cycle bypass on a/c, old value on b.
    we = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5_A5A5; rd_addr = {4'd3, 4'd7};
    #1;
    check("bypass_a", get_rd(0, 0), 32'hA5A5_A5A5);
    check("nobypass_b", get_rd(1, 0), 32'h0);
    step();

    // Out-of-range on the 12-entry file: write to 13 dropped, read of 13 is zero.
    write(4'd13, 32'h1313_1313);
    idle(); rd_addr = {4'd13, 4'd13};
    #1;
    check("oor_read_c", get_rd(2, 0), 32'h0);
    check("oor_write_a", get_rd(0, 0), 32'h1313_1313);
    step();

    // Soft clear: fill, pulse clear with a concurrent write, keep writing during the sweep.
    for (int a = 1; a < 16; a++) write(4'(a), 32'(a));
    read_all();
    we = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFF_FFFF; clr = 1'b1; rd_addr = {4'd3, 4'd2};
    step();
    clr = 1'b0; wr_addr = 4'd9; wr_data = 32'h0000_0055;
    measure_sweep("soft");
    read_all();

    // Async reset in the middle of a soft sweep.
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 8'($urandom);
      step();
    end
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) m_start_clear(k);
    step(); step();
    reset = 1'b1;
    measure_sweep("midrst");
    read_all();

    // Randomized traffic with occasional soft clears, reads biased toward the write address.
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_data = $urandom;
      clr     = ($urandom_range(0, 49) == 0);
      rd_addr[3:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
      rd_addr[7:4] = 4'($urandom);
      step();
    end
    read_all();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
